// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared request type, funct3 encodings and MMIO map for the LSU arbiter
package lsu_arb_pkg;

    localparam int LSU_ADDR_W = 12;
    localparam int LSU_DATA_W = 32;

    typedef struct packed {
        logic [LSU_ADDR_W-1:0] addr;
        logic [LSU_DATA_W-1:0] wdata;
        logic                  wren;
        logic [2:0]            rwsel;
    } lsu_req_t;

    typedef enum logic [2:0] {
        F3_LB  = 3'b000,
        F3_LH  = 3'b001,
        F3_LW  = 3'b010,
        F3_LBU = 3'b100,
        F3_LHU = 3'b101
    } funct3_e;

    localparam logic [LSU_ADDR_W-1:0] DMEM_BASE = 12'h000;
    localparam logic [LSU_ADDR_W-1:0] DMEM_LAST = 12'h7FF;
    localparam logic [LSU_ADDR_W-1:0] HEX0_ADDR = 12'h800;
    localparam logic [LSU_ADDR_W-1:0] HEX1_ADDR = 12'h810;
    localparam logic [LSU_ADDR_W-1:0] HEX2_ADDR = 12'h820;
    localparam logic [LSU_ADDR_W-1:0] HEX3_ADDR = 12'h830;
    localparam logic [LSU_ADDR_W-1:0] HEX4_ADDR = 12'h840;
    localparam logic [LSU_ADDR_W-1:0] HEX5_ADDR = 12'h850;
    localparam logic [LSU_ADDR_W-1:0] HEX6_ADDR = 12'h860;
    localparam logic [LSU_ADDR_W-1:0] HEX7_ADDR = 12'h870;
    localparam logic [LSU_ADDR_W-1:0] LEDR_ADDR = 12'h880;
    localparam logic [LSU_ADDR_W-1:0] LEDG_ADDR = 12'h890;
    localparam logic [LSU_ADDR_W-1:0] LCD_ADDR  = 12'h8A0;
    localparam logic [LSU_ADDR_W-1:0] SW_ADDR   = 12'h900;
    localparam logic [LSU_ADDR_W-1:0] BTN_ADDR  = 12'h910;

    function automatic logic is_dmem(input logic [LSU_ADDR_W-1:0] a);
        return a <= DMEM_LAST;
    endfunction

endpackage

// File: rtl/lsu_arb_grant.sv
// lsu_arb_grant: one-hot grant select; pref steers a contested cycle to port 1
module lsu_arb_grant (
    input  logic en,
    input  logic p0_valid,
    input  logic p1_valid,
    input  logic pref,
    output logic gnt0,
    output logic gnt1
);

    // port 1 wins if alone or preferred; port 0 otherwise; nothing while disabled
    always_comb begin
        gnt1 = en && p1_valid && (!p0_valid || pref);
        gnt0 = en && p0_valid && !gnt1;
    end

endmodule

// File: rtl/lsu_arb.sv
// lsu_arb: two-port LSU arbiter (core MEM stage = port 0, debug/loader = port 1).
// Define LSU_ARB_RR_EN for round-robin; otherwise fixed priority with a MAX_WAIT starvation guard.
module lsu_arb
    import lsu_arb_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    output logic              p0_ready,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p0_wren,
    input  logic [2:0]        p0_rwsel,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_valid,
    output logic              p1_ready,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic              p1_wren,
    input  logic [2:0]        p1_rwsel,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] lsu_addr,
    output logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_wren,
    output logic [2:0]        lsu_rwsel,
    input  logic [DATA_W-1:0] lsu_rdata
);

    logic gnt0, gnt1, pref;
    logic rvalid_d, rvalid_q;
    logic owner_d, owner_q;

`ifdef LSU_ARB_RR_EN
    logic rr_ptr_d, rr_ptr_q;

    assign pref = rr_ptr_q;

    // preference moves to the port that did not just transfer
    always_comb begin
        rr_ptr_d = gnt0 ? 1'b1 : gnt1 ? 1'b0 : rr_ptr_q;
    end

    // round-robin pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rr_ptr_q <= 1'b0;
        else      rr_ptr_q <= rr_ptr_d;
    end
`else
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_d, wait_cnt_q;

    assign pref = (wait_cnt_q == WAIT_MAX);

    // count denied port-1 cycles, saturating; clear on port-1 transfer or withdrawal
    always_comb begin
        wait_cnt_d = (!p1_valid || gnt1) ? '0 : pref ? wait_cnt_q : wait_cnt_q + 1'b1;
    end

    // starvation counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt_q <= '0;
        else      wait_cnt_q <= wait_cnt_d;
    end
`endif

    lsu_arb_grant u_grant (
        .en       (rst),
        .p0_valid (p0_valid),
        .p1_valid (p1_valid),
        .pref     (pref),
        .gnt0     (gnt0),
        .gnt1     (gnt1)
    );

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;

    // drive the granted request onto the LSU bus; idle bus is a zero word load
    always_comb begin
        lsu_addr  = gnt1 ? p1_addr  : gnt0 ? p0_addr  : '0;
        lsu_wdata = gnt1 ? p1_wdata : gnt0 ? p0_wdata : '0;
        lsu_wren  = gnt1 ? p1_wren  : gnt0 && p0_wren;
        lsu_rwsel = gnt1 ? p1_rwsel : gnt0 ? p0_rwsel : 3'(F3_LW);
    end

    // an accepted load expects data next cycle; remember which port owns it
    always_comb begin
        rvalid_d = (gnt0 && !p0_wren) || (gnt1 && !p1_wren);
        owner_d  = gnt1;
    end

    // response tracking registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid_q <= 1'b0;
            owner_q  <= 1'b0;
        end else begin
            rvalid_q <= rvalid_d;
            owner_q  <= owner_d;
        end
    end

    // route the registered LSU read data to its owner only
    always_comb begin
        p0_rvalid = rvalid_q && !owner_q;
        p1_rvalid = rvalid_q && owner_q;
        p0_rdata  = p0_rvalid ? lsu_rdata : '0;
        p1_rdata  = p1_rvalid ? lsu_rdata : '0;
    end

endmodule
